// File: rtl/hc8_pkg.sv
// Shared types and constants for the HC8 program loader.
package hc8_pkg;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam int unsigned LEN_W     = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLenH,
        StLenL,
        StData,
        StCksum,
        StCheck,
        StRun,
        StErr
    } loader_state_t;

endpackage

// File: rtl/hc8_prog_ram.sv
// Instruction RAM: synchronous write, asynchronous read, no reset.
module hc8_prog_ram #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read sees the pre-edge contents on a same-address write.
    assign rdata = mem[raddr];

endmodule

// File: rtl/hc8_prog_loader.sv
// Framed byte-stream loader for HC8 instruction RAM, plus the core's fetch port.
// Define HC8_LOADER_CKSUM_EN to expect and check a trailing checksum byte.
module hc8_prog_loader
    import hc8_pkg::*;
#(
    parameter int unsigned       ADDR_W = 8,
    parameter int unsigned       DATA_W = 8,
    parameter logic [DATA_W-1:0] FILL   = 8'h00
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       pc,
    output logic [DATA_W-1:0] instr,
    output logic              cpu_nReset,
    output logic              busy,
    output logic              err
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    loader_state_t     state_q;
    logic [DATA_W-1:0] len_hi_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  wr_addr_q;
    logic [DATA_W-1:0] sum_q;
`ifdef HC8_LOADER_CKSUM_EN
    logic [DATA_W-1:0] cksum_q;
`endif

    logic              accept;
    logic [LEN_W-1:0]  len_n;
    logic              len_bad;
    logic              last_byte;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    assign accept    = in_valid && in_ready;
    assign len_n     = {len_hi_q, in_data};
    assign len_bad   = (len_n == '0) || (32'(len_n) > DEPTH);
    assign last_byte = (wr_addr_q + LEN_W'(1)) == len_q;
    assign ram_we    = (state_q == StData) && accept;

    hc8_prog_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_addr_q[ADDR_W-1:0]),
        .wdata (in_data),
        .raddr (pc[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    // Addresses beyond the RAM return FILL instead of aliasing.
    assign instr = ((pc >> ADDR_W) == 16'd0) ? ram_rdata : FILL;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= StIdle;
            cpu_nReset <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            in_ready   <= 1'b1;
            len_hi_q   <= '0;
            len_q      <= '0;
            wr_addr_q  <= '0;
            sum_q      <= '0;
`ifdef HC8_LOADER_CKSUM_EN
            cksum_q    <= '0;
`endif
        end else begin
            case (state_q)
                StIdle, StRun, StErr: begin
                    if (accept && (in_data == SYNC_BYTE)) begin
                        state_q    <= StLenH;
                        cpu_nReset <= 1'b0;
                        busy       <= 1'b1;
                        err        <= 1'b0;
                        wr_addr_q  <= '0;
                        sum_q      <= '0;
                    end
                end
                StLenH: begin
                    if (accept) begin
                        len_hi_q <= in_data;
                        state_q  <= StLenL;
                    end
                end
                StLenL: begin
                    if (accept) begin
                        if (len_bad) begin
                            state_q <= StErr;
                            busy    <= 1'b0;
                            err     <= 1'b1;
                        end else begin
                            len_q   <= len_n;
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (accept) begin
                        sum_q     <= sum_q + in_data;
                        wr_addr_q <= wr_addr_q + LEN_W'(1);
                        if (last_byte) begin
`ifdef HC8_LOADER_CKSUM_EN
                            state_q  <= StCksum;
`else
                            state_q  <= StCheck;
                            in_ready <= 1'b0;
`endif
                        end
                    end
                end
`ifdef HC8_LOADER_CKSUM_EN
                StCksum: begin
                    if (accept) begin
                        cksum_q  <= in_data;
                        state_q  <= StCheck;
                        in_ready <= 1'b0;
                    end
                end
`endif
                StCheck: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
`ifdef HC8_LOADER_CKSUM_EN
                    if (cksum_q == sum_q) begin
                        state_q    <= StRun;
                        cpu_nReset <= 1'b1;
                    end else begin
                        state_q <= StErr;
                        err     <= 1'b1;
                    end
`else
                    state_q    <= StRun;
                    cpu_nReset <= 1'b1;
`endif
                end
                default: begin
                    state_q    <= StIdle;
                    cpu_nReset <= 1'b0;
                    busy       <= 1'b0;
                    in_ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hc8_prog_loader.sv
// Directed self-checking bench for hc8_prog_loader.
module tb_hc8_prog_loader;

    logic        clk = 1'b0;
    logic        nReset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] pc;
    logic [7:0]  instr;
    logic        cpu_nReset;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    hc8_prog_loader #(
        .ADDR_W (8),
        .DATA_W (8),
        .FILL   (8'h00)
    ) dut (
        .clk        (clk),
        .nReset     (nReset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pc         (pc),
        .instr      (instr),
        .cpu_nReset (cpu_nReset),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Present one byte from a negedge and hold it through the accepting posedge.
    task automatic send(input logic [7:0] b);
        int guard;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        if (guard == 16) begin
            checks++;
            errors++;
            $display("FAIL handshake: observed in_ready stuck 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n, input logic [7:0] junk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_data  = junk;
            in_valid = 1'b0;
            check("gap_ready", {15'd0, in_ready}, 16'd1);
        end
    endtask

    task automatic fetch(input string tag, input logic [15:0] a, input logic [7:0] exp);
        pc = a;
        #1;
        check(tag, {8'd0, instr}, {8'd0, exp});
    endtask

    // Loads 11 22 33 and waits for the release edge.
    task automatic load_abc();
        send(8'hA5); send(8'h00); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33);
`ifdef HC8_LOADER_CKSUM_EN
        send(8'h66);
`endif
        @(posedge clk);
        #1;
        check("abc_run", {15'd0, cpu_nReset}, 16'd1);
    endtask

    initial begin
        nReset   = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        pc       = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_cpu",   {15'd0, cpu_nReset}, 16'd0);
        check("rst_busy",  {15'd0, busy},       16'd0);
        check("rst_err",   {15'd0, err},        16'd0);
        check("rst_ready", {15'd0, in_ready},   16'd1);
        nReset = 1'b1;

        // 1: good frame, release one edge after the last byte
        send(8'hA5);
        check("t1_busy", {15'd0, busy}, 16'd1);
        send(8'h00); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33);
`ifdef HC8_LOADER_CKSUM_EN
        send(8'h66);
`endif
        check("t1_chk_ready", {15'd0, in_ready},   16'd0);
        check("t1_chk_cpu",   {15'd0, cpu_nReset}, 16'd0);
        check("t1_chk_busy",  {15'd0, busy},       16'd1);
        @(posedge clk);
        #1;
        check("t1_run_cpu",   {15'd0, cpu_nReset}, 16'd1);
        check("t1_run_busy",  {15'd0, busy},       16'd0);
        check("t1_run_ready", {15'd0, in_ready},   16'd1);
        fetch("t1_pc0", 16'h0000, 8'h11);
        fetch("t1_pc1", 16'h0001, 8'h22);
        fetch("t1_pc2", 16'h0002, 8'h33);
        send(8'h66);
        check("t1_drop_cpu", {15'd0, cpu_nReset}, 16'd1);

`ifdef HC8_LOADER_CKSUM_EN
        // 2: bad checksum
        send(8'hA5); send(8'h00); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33); send(8'h67);
        @(posedge clk);
        #1;
        check("t2_err", {15'd0, err},        16'd1);
        check("t2_cpu", {15'd0, cpu_nReset}, 16'd0);
        load_abc();
        check("t2_err_clr", {15'd0, err}, 16'd0);
`endif

        // 3: zero and oversize lengths
        send(8'hA5); send(8'h00); send(8'h00);
        check("t3_zero_err",  {15'd0, err},        16'd1);
        check("t3_zero_busy", {15'd0, busy},       16'd0);
        check("t3_zero_cpu",  {15'd0, cpu_nReset}, 16'd0);
        fetch("t3_pc0", 16'h0000, 8'h11);
        send(8'hA5);
        check("t3_sync_clr", {15'd0, err}, 16'd0);
        send(8'h01); send(8'h01);
        check("t3_big_err", {15'd0, err}, 16'd1);
        fetch("t3_pc1", 16'h0001, 8'h22);
        load_abc();

        // 4: reload from RUN; A5 in the payload is data
        send(8'hA5);
        check("t4_cpu_drop", {15'd0, cpu_nReset}, 16'd0);
        check("t4_busy",     {15'd0, busy},       16'd1);
        send(8'h00); send(8'h01); send(8'hA5);
`ifdef HC8_LOADER_CKSUM_EN
        send(8'hA5);
`endif
        @(posedge clk);
        #1;
        check("t4_run", {15'd0, cpu_nReset}, 16'd1);
        fetch("t4_pc0", 16'h0000, 8'hA5);
        fetch("t4_pc1", 16'h0001, 8'h22);
        fetch("t4_pc2", 16'h0002, 8'h33);

        // 5: async reset mid-DATA
        send(8'hA5); send(8'h00); send(8'h04);
        send(8'hDE); send(8'hAD);
        #2;
        nReset = 1'b0;
        #1;
        check("t5_cpu",   {15'd0, cpu_nReset}, 16'd0);
        check("t5_busy",  {15'd0, busy},       16'd0);
        check("t5_ready", {15'd0, in_ready},   16'd1);
        @(negedge clk);
        nReset = 1'b1;
        fetch("t5_pc0", 16'h0000, 8'hDE);
        fetch("t5_pc1", 16'h0001, 8'hAD);
        fetch("t5_pc2", 16'h0002, 8'h33);

        // 6: out-of-range fetch, gapped stream with A5 on the bus while invalid
        fetch("t6_fill100", 16'h0100, 8'h00);
        fetch("t6_fillfff", 16'hFFFF, 8'h00);
        send(8'hA5);
        idle(2, 8'hA5);
        send(8'h00);
        idle(1, 8'hA5);
        send(8'h02);
        send(8'h5A);
        idle(3, 8'h77);
        send(8'hC3);
`ifdef HC8_LOADER_CKSUM_EN
        idle(1, 8'h00);
        send(8'h1D);
`endif
        check("t6_chk_ready", {15'd0, in_ready}, 16'd0);
        @(posedge clk);
        #1;
        check("t6_run", {15'd0, cpu_nReset}, 16'd1);
        fetch("t6_pc0", 16'h0000, 8'h5A);
        fetch("t6_pc1", 16'h0001, 8'hC3);
        fetch("t6_pc2", 16'h0002, 8'h33);
        idle(2, 8'hA5);
        check("t6_invalid_sync", {15'd0, cpu_nReset}, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
